// File: rtl/tail_packer.sv
// Instruction-word packer: opcodes fill a 64-bit word upward from nibble 0,
// tail nibbles fill downward from nibble 15; closed words leave over valid/ready.
module tail_packer #(
   parameter logic [3:0] PAD       = 4'h0,
   parameter bit         AUTO_EMIT = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_op,
   input  logic [2:0]  in_len,
   input  logic [27:0] in_tail,
   input  logic        in_flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_data,
   output logic [4:0]  out_cnt
);

   localparam logic [0:0] FILL = 1'b0;
   localparam logic [0:0] HOLD = 1'b1;
   localparam logic [63:0] PAD_WORD = {16{PAD}};

   logic [0:0]  state_r;
   logic [4:0]  op_cnt_r;
   logic [3:0]  tl_cnt_r;
   logic [63:0] buf_r;

   logic [4:0]  total_s;
   logic        fits_s;
   logic        accept_s;
   logic        filled_s;
   logic        close_s;
   logic [4:0]  op_next_s;
   logic [3:0]  tl_next_s;
   logic [63:0] buf_next_s;

   // Nibbles in use after this instruction; at most 16+1+7, so 5 bits never wrap.
   assign total_s  = op_cnt_r + {1'b0, tl_cnt_r} + 5'd1 + {2'b00, in_len};
   assign fits_s   = (total_s <= 5'd16);
   assign in_ready = (state_r == FILL) & fits_s;
   assign accept_s = in_valid & in_ready;
   assign filled_s = accept_s & (total_s == 5'd16);

   // Overflow never fires on an empty buffer since one instruction is at most 8 nibbles.
   assign close_s = (state_r == FILL) &
                    ((in_valid & ~fits_s & (op_cnt_r != 5'd0)) |
                     (in_flush & (op_cnt_r != 5'd0)) |
                     (AUTO_EMIT & filled_s));

   // Next counter values including the instruction accepted this cycle.
   always_comb begin
      op_next_s = op_cnt_r;
      tl_next_s = tl_cnt_r;
      if (accept_s) begin
         op_next_s = op_cnt_r + 5'd1;
         tl_next_s = tl_cnt_r + {1'b0, in_len};
      end else begin
         op_next_s = op_cnt_r;
         tl_next_s = tl_cnt_r;
      end
   end

   // Next buffer contents; tail nibbles j>=in_len rewrite their slot's current value.
   always_comb begin
      buf_next_s = buf_r;
      if (accept_s) begin
         buf_next_s[{op_cnt_r[3:0], 2'b00} +: 4] = in_op;
         for (int j = 0; j < 7; j++) begin
            buf_next_s[{4'd15 - tl_cnt_r - 4'(j), 2'b00} +: 4] =
               (3'(j) < in_len) ? in_tail[4*j +: 4]
                                : buf_next_s[{4'd15 - tl_cnt_r - 4'(j), 2'b00} +: 4];
         end
      end else begin
         buf_next_s = buf_r;
      end
   end

   // FILL/HOLD sequencing, buffer, counters and the registered output word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= FILL;
         op_cnt_r  <= 5'd0;
         tl_cnt_r  <= 4'd0;
         buf_r     <= PAD_WORD;
         out_valid <= 1'b0;
         out_data  <= PAD_WORD;
         out_cnt   <= 5'd0;
      end else begin
         case (state_r)
            FILL: begin
               buf_r    <= buf_next_s;
               op_cnt_r <= op_next_s;
               tl_cnt_r <= tl_next_s;
               if (close_s) begin
                  out_data  <= buf_next_s;
                  out_cnt   <= op_next_s;
                  out_valid <= 1'b1;
                  state_r   <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  buf_r     <= PAD_WORD;
                  op_cnt_r  <= 5'd0;
                  tl_cnt_r  <= 4'd0;
                  out_valid <= 1'b0;
                  state_r   <= FILL;
               end
            end
            default: begin
               state_r   <= FILL;
               op_cnt_r  <= 5'd0;
               tl_cnt_r  <= 4'd0;
               buf_r     <= PAD_WORD;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tail_packer.sv
// Bench for tail_packer: directed scenarios plus random traffic, scored against
// a queue-based model of the opcode and tail regions.
module tb_tail_packer;

   localparam logic [3:0] PAD = 4'h0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  in_op = 4'h0;
   logic [2:0]  in_len = 3'd0;
   logic [27:0] in_tail = 28'h0;
   logic        in_flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_data;
   logic [4:0]  out_cnt;

   tail_packer #(.PAD(PAD), .AUTO_EMIT(1'b1)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_len(in_len), .in_tail(in_tail), .in_flush(in_flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_cnt(out_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] d;
      logic [4:0]  c;
   } exp_t;

   exp_t        q[$];
   logic [3:0]  m_ops[$];
   logic [3:0]  m_tails[$];
   bit          m_hold = 1'b0;
   logic [63:0] m_word = 64'h0;
   logic [4:0]  m_cnt = 5'd0;
   int          n_chk = 0;
   int          n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Word as the rules describe it: opcodes from nibble 0 up, tails from 15 down.
   function automatic logic [63:0] build();
      logic [63:0] w;
      w = {16{PAD}};
      for (int k = 0; k < m_ops.size(); k++) w[4*k +: 4] = m_ops[k];
      for (int i = 0; i < m_tails.size(); i++) w[4*(15-i) +: 4] = m_tails[i];
      return w;
   endfunction

   task automatic step(input bit v, input logic [3:0] op, input logic [2:0] len,
                       input logic [27:0] tl, input bit fl, input bit ordy);
      int used;
      int ops_before;
      bit exp_rdy;
      bit acc;
      bit close;
      exp_t e;
      @(negedge clk);
      in_valid = v; in_op = op; in_len = len; in_tail = tl; in_flush = fl; out_ready = ordy;
      #1;
      used = m_ops.size() + m_tails.size();
      exp_rdy = !m_hold && (used + 1 + int'(len) <= 16);
      chk("in_ready", {63'h0, in_ready}, {63'h0, exp_rdy});
      chk("out_valid", {63'h0, out_valid}, {63'h0, m_hold});
      if (m_hold) begin
         chk("hold_data", out_data, m_word);
         chk("hold_cnt", {59'h0, out_cnt}, {59'h0, m_cnt});
         if (ordy) begin
            m_hold = 1'b0;
            m_ops.delete();
            m_tails.delete();
         end
      end else begin
         ops_before = m_ops.size();
         acc = v && exp_rdy;
         if (acc) begin
            m_ops.push_back(op);
            for (int j = 0; j < int'(len); j++) m_tails.push_back(tl[4*j +: 4]);
         end
         close = (v && !exp_rdy && ops_before > 0) || (fl && ops_before > 0) ||
                 (acc && (m_ops.size() + m_tails.size() == 16));
         if (close) begin
            m_word = build();
            m_cnt  = 5'(m_ops.size());
            m_hold = 1'b1;
            e.d = m_word;
            e.c = m_cnt;
            q.push_back(e);
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; in_flush = 1'b0; in_len = 3'd0; out_ready = 1'b0;
      m_ops.delete(); m_tails.delete(); m_hold = 1'b0; q.delete();
      #1;
      chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
      chk("rst_out_data", out_data, {16{PAD}});
      chk("rst_out_cnt", {59'h0, out_cnt}, 64'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", {63'h0, in_ready}, 64'h1);
   endtask

   // Monitor: every handshake must consume the oldest predicted word.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (!rst && out_valid && out_ready) begin
            chk("word_expected", {63'h0, q.size() != 0}, 64'h1);
            if (q.size() != 0) begin
               e = q.pop_front();
               chk("mon_data", out_data, e.d);
               chk("mon_cnt", {59'h0, out_cnt}, {59'h0, e.c});
            end
         end
      end
   end

   initial begin
      do_reset();

      for (int i = 1; i <= 16; i++) step(1'b1, 4'(i), 3'd0, 28'h0, 1'b0, 1'b1);
      step(1'b0, 4'h0, 3'd0, 28'h0, 1'b0, 1'b0);
      chk("t2_data", out_data, 64'h0FEDCBA987654321);
      chk("t2_cnt", {59'h0, out_cnt}, 64'd16);
      step(1'b0, 4'h0, 3'd0, 28'h0, 1'b0, 1'b1);

      step(1'b1, 4'hA, 3'd2, 28'h0000053, 1'b0, 1'b0);
      step(1'b0, 4'h0, 3'd0, 28'h0, 1'b1, 1'b0);
      step(1'b0, 4'h0, 3'd0, 28'h0, 1'b0, 1'b0);
      chk("t3_data", out_data, 64'h350000000000000A);
      chk("t3_cnt", {59'h0, out_cnt}, 64'd1);
      step(1'b0, 4'h0, 3'd0, 28'h0, 1'b0, 1'b1);

      step(1'b1, 4'h1, 3'd6, 28'h0654321, 1'b0, 1'b0);
      step(1'b1, 4'h2, 3'd6, 28'h0CBA987, 1'b0, 1'b0);
      step(1'b1, 4'h7, 3'd2, 28'h0000021, 1'b0, 1'b0);
      chk("t4_in_ready", {63'h0, in_ready}, 64'h0);
      step(1'b1, 4'h7, 3'd2, 28'h0000021, 1'b0, 1'b0);
      chk("t4_cnt", {59'h0, out_cnt}, 64'd2);
      step(1'b1, 4'h7, 3'd2, 28'h0000021, 1'b0, 1'b1);
      step(1'b1, 4'h7, 3'd2, 28'h0000021, 1'b0, 1'b0);
      step(1'b0, 4'h0, 3'd0, 28'h0, 1'b1, 1'b0);
      step(1'b0, 4'h0, 3'd0, 28'h0, 1'b0, 1'b0);
      chk("t4_next_word", out_data, 64'h1200000000000007);

      for (int i = 0; i < 5; i++) step(1'b0, 4'h0, 3'd0, 28'h0, 1'b0, 1'b0);
      step(1'b0, 4'h0, 3'd0, 28'h0, 1'b0, 1'b1);
      step(1'b0, 4'h0, 3'd0, 28'h0, 1'b0, 1'b0);

      for (int i = 0; i < 3; i++) step(1'b1, 4'(i + 3), 3'd1, 28'h5, 1'b0, 1'b1);
      do_reset();
      step(1'b0, 4'h0, 3'd0, 28'h0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 3'd0, 28'h0, 1'b0, 1'b1);

      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 199) == 0) do_reset();
         else step($urandom_range(0, 9) < 7, 4'($urandom), 3'($urandom_range(0, 7)),
                   28'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6);
      end

      step(1'b0, 4'h0, 3'd0, 28'h0, 1'b0, 1'b1);
      step(1'b0, 4'h0, 3'd0, 28'h0, 1'b1, 1'b1);
      step(1'b0, 4'h0, 3'd0, 28'h0, 1'b0, 1'b1);
      step(1'b0, 4'h0, 3'd0, 28'h0, 1'b0, 1'b1);
      @(negedge clk);
      #3;
      chk("queue_empty", 64'(q.size()), 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
